pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter PC_W, default 8: program counter width; byte address into the instruction ROM.
REQ-002 Parameter CNT_W, default 16: retired-instruction counter width.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  level; leaves IDLE or HALT when high.
REQ-006 instr  input  32  ROM data; valid one cycle after pc is presented.
REQ-007 branch, mem_read, mem_write, reg_write  input  1 each  decoded control bits for the instruction held in ir.
REQ-008 zero  input  1  ALU zero flag.
REQ-009 imm  input  32  immediate-generator output for ir.
REQ-010 pc  output  PC_W  current fetch address.
REQ-011 ir  output  32  latched instruction register feeding decode, register file and immediate generator.
REQ-012 ram_we  output  1  one-cycle data-RAM write strobe.
REQ-013 reg_we  output  1  one-cycle register-file write strobe.
REQ-014 mem_to_reg  output  1  write-data select: 1 selects RAM, 0 selects ALU; asserted only in WB.
REQ-015 halted  output  1  high while in HALT.
REQ-016 retired  output  CNT_W  count of completed instructions.

Function
REQ-017 States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT; one-hot or binary encoding is free.
REQ-018 IDLE: hold; go to FETCH on the first clk edge where start=1.
REQ-019 FETCH: pc drives the ROM; the next state is DECODE unconditionally, giving one cycle of ROM latency.
REQ-020 DECODE: if instr==0, go to HALT without changing ir; otherwise ir<=instr and go to EXEC.
REQ-021 EXEC, branch=1: taken = ir[12] XOR zero; pc <= taken ? pc + imm[PC_W-2:0]<<1 : pc+4.
REQ-022 EXEC, branch=1 (cont.): the branch issues no strobes, increments retired and returns to FETCH.
REQ-023 EXEC, mem_write=1: ram_we=1 for exactly this cycle; pc<=pc+4; retired increments; next state is FETCH.
REQ-024 EXEC, mem_read=1: no strobes; next state is MEM.
REQ-025 EXEC, otherwise: reg_we equals reg_write for this cycle; pc<=pc+4; retired increments; next state is FETCH.
REQ-026 Priority in EXEC when several control bits are set: branch, then mem_write, then mem_read, then default.
REQ-027 MEM: wait one cycle for RAM read latency; next state is WB.
REQ-028 WB: reg_we=1 and mem_to_reg=1; pc<=pc+4; retired increments; next state is FETCH.
REQ-029 PC arithmetic is modulo 2^PC_W: pc 8'hFC+4 wraps to 8'h00, and a negative branch offset wraps the same way; no error is flagged.
REQ-030 retired saturates at all-ones and does not wrap.
REQ-031 HALT: halted=1 and pc is frozen; on start=1, go to FETCH with pc+4, skipping the zero word.
REQ-032 ram_we, reg_we and mem_to_reg are never high outside the states listed above and are never high in the same cycle as a pc update from a branch.
REQ-033 All outputs are registered or decoded from state only; there is no combinational path from instr to any strobe.

Reset
REQ-034 While rst_n=0, regardless of clk: state=IDLE, pc=0, ir=0, retired=0, and ram_we, reg_we, mem_to_reg, halted all 0.
REQ-035 Reset assertion in any state, including the middle of an instruction, aborts that instruction with no strobe emitted afterwards.
REQ-036 After rst_n rises, the first fetch occurs from pc=0 only after start=1.

Verification
REQ-037 Reset, start=1, R-type word 32'h002081B3 -> FETCH, DECODE, EXEC; reg_we high for 1 cycle on cycle 3; pc=4; retired=1.
REQ-038 lw, mem_read=1 -> EXEC, MEM, WB; reg_we=mem_to_reg=1 only in WB; 5 cycles per instruction; pc+4.
REQ-039 beq with zero=1 and imm=8 at pc=8 -> pc=24, no strobes; the same beq with zero=0 -> pc=12.
REQ-040 instr=0 at pc=16 -> halted=1 and pc stays 16 for 10 cycles; start=1 -> FETCH at pc=20.
REQ-041 pc=8'hFC, non-branch instruction -> pc=8'h00; retired forced to 16'hFFFF then one more instruction retired -> retired stays 16'hFFFF.
REQ-042 rst_n pulled low in the MEM state of an sw/lw sequence -> all outputs go to 0 immediately with no reg_we pulse, and state is IDLE.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// Bus between the multi-cycle fetch/decode sequencer and its ROM, decoder,
// register file and data RAM; "master" is the sequencer side.
interface pc_sequencer_if #(
   parameter int PC_W  = 8,
   parameter int CNT_W = 16
);
   logic             start;
   logic [31:0]      instr;
   logic             branch;
   logic             mem_read;
   logic             mem_write;
   logic             reg_write;
   logic             zero;
   logic [31:0]      imm;
   logic [PC_W-1:0]  pc;
   logic [31:0]      ir;
   logic             ram_we;
   logic             reg_we;
   logic             mem_to_reg;
   logic             halted;
   logic [CNT_W-1:0] retired;
   logic [2:0]       state;

   modport master (
      input  start, instr, branch, mem_read, mem_write, reg_write, zero, imm,
      output pc, ir, ram_we, reg_we, mem_to_reg, halted, retired, state
   );

   modport slave (
      output start, instr, branch, mem_read, mem_write, reg_write, zero, imm,
      input  pc, ir, ram_we, reg_we, mem_to_reg, halted, retired, state
   );
endinterface

// File: rtl/pc_sequencer.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC(/MEM/WB) per instruction,
// a zero word halts, start resumes past it. Current state is exposed on bus.state.
module pc_sequencer #(
   parameter int PC_W  = 8,
   parameter int CNT_W = 16
) (
   input  logic clk,
   input  logic rst_n,
   pc_sequencer_if.master bus
);
   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_FETCH  = 3'd1;
   localparam logic [2:0] S_DECODE = 3'd2;
   localparam logic [2:0] S_EXEC   = 3'd3;
   localparam logic [2:0] S_MEM    = 3'd4;
   localparam logic [2:0] S_WB     = 3'd5;
   localparam logic [2:0] S_HALT   = 3'd6;

   logic [2:0]       state_q, state_d;
   logic [PC_W-1:0]  pc_q, pc_d;
   logic [31:0]      ir_q, ir_d;
   logic [CNT_W-1:0] retired_q;
   logic             retire;
   logic             taken;
   logic [PC_W-1:0]  pc_plus4;
   logic [PC_W-1:0]  br_target;

   // Offset is a halfword count; the shift keeps branch targets 2-byte aligned.
   assign pc_plus4  = pc_q + PC_W'(4);
   assign br_target = pc_q + {bus.imm[PC_W-2:0], 1'b0};
   assign taken     = ir_q[12] ^ bus.zero;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      retire  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.start) state_d = S_FETCH;
         end
         S_FETCH: begin
            state_d = S_DECODE;
         end
         S_DECODE: begin
            if (bus.instr == 32'd0) begin
               state_d = S_HALT;
            end else begin
               ir_d    = bus.instr;
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            if (bus.branch) begin
               pc_d    = taken ? br_target : pc_plus4;
               retire  = 1'b1;
               state_d = S_FETCH;
            end else if (bus.mem_write) begin
               pc_d    = pc_plus4;
               retire  = 1'b1;
               state_d = S_FETCH;
            end else if (bus.mem_read) begin
               state_d = S_MEM;
            end else begin
               pc_d    = pc_plus4;
               retire  = 1'b1;
               state_d = S_FETCH;
            end
         end
         S_MEM: begin
            state_d = S_WB;
         end
         S_WB: begin
            pc_d    = pc_plus4;
            retire  = 1'b1;
            state_d = S_FETCH;
         end
         S_HALT: begin
            if (bus.start) begin
               pc_d    = pc_plus4;
               state_d = S_FETCH;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         pc_q      <= '0;
         ir_q      <= '0;
         retired_q <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         if (retire && (retired_q != {CNT_W{1'b1}})) retired_q <= retired_q + CNT_W'(1);
      end
   end

   // Strobes depend on the state and the decode of the registered ir only,
   // so reset (state=IDLE) clears them at once and instr never reaches them.
   assign bus.ram_we     = (state_q == S_EXEC) && !bus.branch && bus.mem_write;
   assign bus.reg_we     = (state_q == S_WB) ||
                           ((state_q == S_EXEC) && !bus.branch && !bus.mem_write &&
                            !bus.mem_read && bus.reg_write);
   assign bus.mem_to_reg = (state_q == S_WB);
   assign bus.halted     = (state_q == S_HALT);
   assign bus.pc         = pc_q;
   assign bus.ir         = ir_q;
   assign bus.retired    = retired_q;
   assign bus.state      = state_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: hand-computed pc/strobe/retired vectors,
// plus a narrow-counter instance that must saturate.
module tb_pc_sequencer;
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_FETCH = 3'd1;
   localparam logic [2:0] ST_MEM   = 3'd4;
   localparam logic [2:0] ST_HALT  = 3'd6;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic sat_rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   ret_m = 0;
   logic [7:0] exp_q[$];

   pc_sequencer_if #(.PC_W(8), .CNT_W(16)) bus ();
   pc_sequencer_if #(.PC_W(8), .CNT_W(3))  sat_bus ();

   pc_sequencer #(.PC_W(8), .CNT_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   pc_sequencer #(.PC_W(8), .CNT_W(3))  dut_sat (.clk(clk), .rst_n(sat_rst_n), .bus(sat_bus));

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   // Presents one instruction from FETCH and follows it back to FETCH.
   task automatic do_instr(input string tag, input logic [31:0] word,
                           input logic br, input logic mr, input logic mw,
                           input logic rw, input logic z, input logic [31:0] immv,
                           input int exp_cyc, input int exp_reg_cyc,
                           input int exp_ram_n, input int exp_m2r_n,
                           input logic [7:0] exp_pc);
      int cyc, reg_n, reg_cyc, ram_n, m2r_n;
      logic [31:0] ir_seen;
      check({tag, "_at_fetch"}, 32'(bus.state), 32'(ST_FETCH));
      bus.instr = word; bus.branch = br; bus.mem_read = mr; bus.mem_write = mw;
      bus.reg_write = rw; bus.zero = z; bus.imm = immv;
      cyc = 1; reg_n = 0; reg_cyc = 0; ram_n = 0; m2r_n = 0; ir_seen = '0;
      forever begin
         if (bus.reg_we) begin reg_n++; reg_cyc = cyc; end
         if (bus.ram_we) ram_n++;
         if (bus.mem_to_reg) m2r_n++;
         if (cyc == 3) ir_seen = bus.ir;
         step();
         if (bus.state == ST_FETCH || bus.state == ST_HALT || cyc >= 8) break;
         cyc++;
      end
      ret_m++;
      check({tag, "_cycles"}, 32'(cyc), 32'(exp_cyc));
      check({tag, "_reg_we_n"}, 32'(reg_n), (exp_reg_cyc != 0) ? 32'd1 : 32'd0);
      check({tag, "_reg_we_cyc"}, 32'(reg_cyc), 32'(exp_reg_cyc));
      check({tag, "_ram_we_n"}, 32'(ram_n), 32'(exp_ram_n));
      check({tag, "_m2r_n"}, 32'(m2r_n), 32'(exp_m2r_n));
      check({tag, "_ir"}, ir_seen, word);
      check({tag, "_pc"}, 32'(bus.pc), 32'(exp_pc));
      check({tag, "_retired"}, 32'(bus.retired), 32'(ret_m));
   endtask

   initial begin
      sat_bus.start = 1'b1; sat_bus.instr = 32'h00000013; sat_bus.branch = 1'b0;
      sat_bus.mem_read = 1'b0; sat_bus.mem_write = 1'b0; sat_bus.reg_write = 1'b1;
      sat_bus.zero = 1'b0; sat_bus.imm = '0;
      bus.start = 1'b0; bus.instr = '0; bus.branch = 1'b0; bus.mem_read = 1'b0;
      bus.mem_write = 1'b0; bus.reg_write = 1'b0; bus.zero = 1'b0; bus.imm = '0;

      // Reset values while rst_n is low
      #1;
      check("rst_pc", 32'(bus.pc), 32'd0);
      check("rst_ir", bus.ir, 32'd0);
      check("rst_retired", 32'(bus.retired), 32'd0);
      check("rst_strobes", {29'd0, bus.ram_we, bus.reg_we, bus.mem_to_reg}, 32'd0);
      check("rst_halted", 32'(bus.halted), 32'd0);
      check("rst_state", 32'(bus.state), 32'(ST_IDLE));
      step(); step();
      rst_n = 1'b1; sat_rst_n = 1'b1;
      step(); step();
      check("idle_hold", 32'(bus.state), 32'(ST_IDLE));
      check("idle_pc", 32'(bus.pc), 32'd0);

      bus.start = 1'b1;
      step();
      bus.start = 1'b0;

      do_instr("rtype", 32'h002081B3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 3, 3, 0, 0, 8'd4);
      do_instr("sw", 32'h0030A023, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 3, 0, 1, 0, 8'd8);
      do_instr("beq_taken", 32'h00208463, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'd8, 3, 0, 0, 0, 8'd24);
      do_instr("beq_back", 32'h00208463, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFFFFF8, 3, 0, 0, 0, 8'd8);
      do_instr("beq_not", 32'h00208463, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd8, 3, 0, 0, 0, 8'd12);
      do_instr("lw", 32'h0000A183, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 5, 5, 0, 1, 8'd16);

      // Zero word at pc=16 halts and keeps ir
      check("halt_at_fetch", 32'(bus.state), 32'(ST_FETCH));
      bus.instr = 32'd0;
      step(); step();
      check("halt_state", 32'(bus.state), 32'(ST_HALT));
      check("halt_flag", 32'(bus.halted), 32'd1);
      check("halt_ir", bus.ir, 32'h0000A183);
      check("halt_retired", 32'(bus.retired), 32'(ret_m));
      for (int i = 0; i < 10; i++) begin
         step();
         check("halt_pc", 32'(bus.pc), 32'd16);
      end
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      check("resume_state", 32'(bus.state), 32'(ST_FETCH));
      check("resume_pc", 32'(bus.pc), 32'd20);
      check("resume_halted", 32'(bus.halted), 32'd0);

      do_instr("bne_taken", 32'h00209463, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd6, 3, 0, 0, 0, 8'd32);
      do_instr("bne_not", 32'h00209463, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'd6, 3, 0, 0, 0, 8'd36);
      do_instr("sw_prio", 32'h0030A023, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 3, 0, 1, 0, 8'd40);
      do_instr("alu_nowr", 32'h002081B3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 3, 0, 0, 0, 8'd44);

      // Straight-line code up to 8'hFC, then the wrap to 8'h00
      for (int p = 48; p <= 256; p += 4) exp_q.push_back(8'(p));
      while (exp_q.size() > 0) begin
         logic [7:0] e;
         e = exp_q.pop_front();
         do_instr("seq", 32'h002081B3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 3, 3, 0, 0, e);
      end
      check("wrap_pc", 32'(bus.pc), 32'd0);

      // Reset in MEM of a load
      bus.instr = 32'h0000A183; bus.branch = 1'b0; bus.mem_read = 1'b1;
      bus.mem_write = 1'b0; bus.reg_write = 1'b1;
      step(); step(); step();
      check("mid_mem_state", 32'(bus.state), 32'(ST_MEM));
      rst_n = 1'b0;
      #1;
      check("mid_rst_state", 32'(bus.state), 32'(ST_IDLE));
      check("mid_rst_pc", 32'(bus.pc), 32'd0);
      check("mid_rst_ir", bus.ir, 32'd0);
      check("mid_rst_retired", 32'(bus.retired), 32'd0);
      check("mid_rst_strobes", {28'd0, bus.ram_we, bus.reg_we, bus.mem_to_reg, bus.halted}, 32'd0);
      step();
      check("mid_rst_hold_reg_we", 32'(bus.reg_we), 32'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("post_rst_reg_we", 32'(bus.reg_we), 32'd0);
         check("post_rst_idle", 32'(bus.state), 32'(ST_IDLE));
      end

      // Narrow counter has run long enough to saturate at 3'b111
      check("sat_retired", 32'(sat_bus.retired), 32'd7);
      for (int i = 0; i < 6; i++) step();
      check("sat_retired_hold", 32'(sat_bus.retired), 32'd7);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
